// File: rtl/pong_score_keeper_pkg.sv
// Shared types and constants for the ping-pong scoreboard.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } score_state_t;

    typedef logic [7:0] bcd2_t;

    localparam logic  P1      = 1'b0;
    localparam logic  P2      = 1'b1;
    localparam bcd2_t BCD_MAX = 8'h99;

    // Two-digit packed BCD to binary (0..99).
    function automatic logic [6:0] bcd2_to_bin(input bcd2_t v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

endpackage

// File: rtl/pong_score_keeper_bcd2_cnt.sv
// Two-digit BCD counter: synchronous clear, increment enable, holds at 99.
// The next value is exported so the caller can judge the point before it lands.
module bcd2_cnt
    import pong_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  inc,
    output bcd2_t value,
    output bcd2_t nxt
);

    logic       ones_wrap;
    logic [3:0] ones_inc;
    logic [3:0] tens_inc;

    // Next value: ones digit wraps 9->0 and carries into tens; 99 holds.
    always_comb begin
        ones_wrap = (value[3:0] == 4'd9);
        ones_inc  = ones_wrap ? 4'd0 : value[3:0] + 4'd1;
        tens_inc  = ones_wrap ? value[7:4] + 4'd1 : value[7:4];
        nxt       = value;
        if (clr) begin
            nxt = '0;
        end else if (inc && (value != BCD_MAX)) begin
            nxt = {tens_inc, ones_inc};
        end
    end

    // Score register.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/pong_score_keeper.sv
// Match scoreboard: per-player BCD scores, first-to-WIN_PTS win-by-2,
// and serve rotation (every SERVE_SWAP points, every point in deuce).
module pong_score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_PTS    = 11,
    parameter int SERVE_SWAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       first_serve,
    input  logic       pt_p1,
    input  logic       pt_p2,
    output logic [7:0] score_p1,
    output logic [7:0] score_p2,
    output logic       serve,
    output logic       playing,
    output logic       game_over,
    output logic       winner
);

    localparam logic [6:0] WIN_B     = 7'(WIN_PTS);
    localparam logic [6:0] DEUCE_B   = 7'(WIN_PTS - 1);
    localparam logic [3:0] SWAP_LAST = 4'(SERVE_SWAP - 1);

    score_state_t state, state_nxt;
    logic         serve_nxt, winner_nxt;
    logic [3:0]   scnt, scnt_nxt;
    logic         inc_p1, inc_p2, counted;
    logic         p1_wins, p2_wins, deuce;
    bcd2_t        nxt_p1, nxt_p2;
    logic [6:0]   bin_p1, bin_p2;

    // A point counts only in PLAY, from a lone pulse, with start absent and
    // the scorer not already saturated at 99.
    assign inc_p1  = (state == PLAY) && !start && pt_p1 && !pt_p2 && (score_p1 != BCD_MAX);
    assign inc_p2  = (state == PLAY) && !start && pt_p2 && !pt_p1 && (score_p2 != BCD_MAX);
    assign counted = inc_p1 | inc_p2;

    bcd2_cnt u_cnt_p1 (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .inc   (inc_p1),
        .value (score_p1),
        .nxt   (nxt_p1)
    );

    bcd2_cnt u_cnt_p2 (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .inc   (inc_p2),
        .value (score_p2),
        .nxt   (nxt_p2)
    );

    // Win and deuce are judged on post-point scores.
    assign bin_p1  = bcd2_to_bin(nxt_p1);
    assign bin_p2  = bcd2_to_bin(nxt_p2);
    assign p1_wins = inc_p1 && (bin_p1 >= WIN_B) && (bin_p1 >= bin_p2 + 7'd2);
    assign p2_wins = inc_p2 && (bin_p2 >= WIN_B) && (bin_p2 >= bin_p1 + 7'd2);
    assign deuce   = (bin_p1 >= DEUCE_B) && (bin_p2 >= DEUCE_B);

    // Next state, winner and serve rotation; start outranks any point.
    always_comb begin
        state_nxt  = state;
        serve_nxt  = serve;
        scnt_nxt   = scnt;
        winner_nxt = winner;
        if (start) begin
            state_nxt = PLAY;
            serve_nxt = first_serve;
            scnt_nxt  = '0;
        end else if (p1_wins || p2_wins) begin
            state_nxt  = OVER;
            winner_nxt = p2_wins ? P2 : P1;
        end else if (counted) begin
            if (deuce || (scnt == SWAP_LAST)) begin
                serve_nxt = ~serve;
                scnt_nxt  = '0;
            end else begin
                scnt_nxt = scnt + 4'd1;
            end
        end
    end

    // Control registers; status flags are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            serve     <= P1;
            scnt      <= '0;
            winner    <= P1;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_nxt;
            serve     <= serve_nxt;
            scnt      <= scnt_nxt;
            winner    <= winner_nxt;
            playing   <= (state_nxt == PLAY);
            game_over <= (state_nxt == OVER);
        end
    end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: vector table, directed corner sequences,
// then random play against a point-counting reference model.
module tb_pong_score_keeper;

    localparam int WIN_PTS    = 11;
    localparam int SERVE_SWAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       first_serve = 1'b0;
    logic       pt_p1 = 1'b0;
    logic       pt_p2 = 1'b0;
    logic [7:0] score_p1, score_p2;
    logic       serve, playing, game_over, winner;

    int checks = 0;
    int errors = 0;

    // Reference model: binary scores and plain flags.
    int m1 = 0, m2 = 0, mcnt = 0;
    bit mserve = 0, mplay = 0, mover = 0, mwin = 0;

    typedef struct packed {
        bit       rst, start, fs, p1, p2;
        bit [7:0] s1, s2;
        bit       serve, playing, over, winner;
    } vec_t;

    vec_t tbl [12];

    pong_score_keeper #(.WIN_PTS(WIN_PTS), .SERVE_SWAP(SERVE_SWAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .first_serve (first_serve),
        .pt_p1       (pt_p1),
        .pt_p2       (pt_p2),
        .score_p1    (score_p1),
        .score_p2    (score_p2),
        .serve       (serve),
        .playing     (playing),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit fs, input bit a, input bit b);
        int me, op;
        bit who;
        if (r) begin
            m1 = 0; m2 = 0; mcnt = 0; mserve = 0; mplay = 0; mover = 0; mwin = 0;
        end else if (s) begin
            m1 = 0; m2 = 0; mcnt = 0; mserve = fs; mplay = 1; mover = 0;
        end else if (mplay && (a != b)) begin
            who = b;
            me  = who ? m2 : m1;
            op  = who ? m1 : m2;
            if (me < 99) begin
                me++;
                if (who) m2 = me; else m1 = me;
                if (me >= WIN_PTS && me - op >= 2) begin
                    mplay = 0; mover = 1; mwin = who;
                end else if (m1 >= WIN_PTS - 1 && m2 >= WIN_PTS - 1) begin
                    mserve = !mserve; mcnt = 0;
                end else begin
                    mcnt++;
                    if (mcnt == SERVE_SWAP) begin
                        mserve = !mserve; mcnt = 0;
                    end
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input bit r, input bit s, input bit fs, input bit a, input bit b);
        @(negedge clk);
        rst = r; start = s; first_serve = fs; pt_p1 = a; pt_p2 = b;
        @(posedge clk);
        #1;
        model_step(r, s, fs, a, b);
        rst = 1'b0; start = 1'b0; pt_p1 = 1'b0; pt_p2 = 1'b0;
    endtask

    task automatic chk_model(input int n);
        chk($sformatf("rnd%0d score_p1", n), score_p1, to_bcd(m1));
        chk($sformatf("rnd%0d score_p2", n), score_p2, to_bcd(m2));
        chk($sformatf("rnd%0d serve", n), {7'd0, serve}, {7'd0, mserve});
        chk($sformatf("rnd%0d playing", n), {7'd0, playing}, {7'd0, mplay});
        chk($sformatf("rnd%0d game_over", n), {7'd0, game_over}, {7'd0, mover});
        if (mover) chk($sformatf("rnd%0d winner", n), {7'd0, winner}, {7'd0, mwin});
    endtask

    initial begin
        bit sv;
        //          rst st fs p1 p2   s1     s2   srv ply ovr win
        tbl[0]  = '{1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 8'h01, 8'h00, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 8'h01, 8'h00, 1, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, 8'h02, 8'h00, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 1, 8'h02, 8'h00, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 8'h02, 8'h01, 0, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 1, 8'h02, 8'h02, 1, 1, 0, 0};
        tbl[10] = '{0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 8'h00, 8'h01, 0, 1, 0, 0};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].start, tbl[i].fs, tbl[i].p1, tbl[i].p2);
            chk($sformatf("vec%0d score_p1", i), score_p1, tbl[i].s1);
            chk($sformatf("vec%0d score_p2", i), score_p2, tbl[i].s2);
            chk($sformatf("vec%0d serve", i), {7'd0, serve}, {7'd0, tbl[i].serve});
            chk($sformatf("vec%0d playing", i), {7'd0, playing}, {7'd0, tbl[i].playing});
            chk($sformatf("vec%0d game_over", i), {7'd0, game_over}, {7'd0, tbl[i].over});
            chk($sformatf("vec%0d winner", i), {7'd0, winner}, {7'd0, tbl[i].winner});
        end

        // BCD carry on P2: 09 -> 10, never a hex digit.
        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 0, 0, 1);
            chk($sformatf("carry%0d ones digit", i), {4'd0, score_p2[3:0]} > 8'd9 ? 8'hFF : 8'h00, 8'h00);
            if (i == 9)  chk("carry score_p2 at 9", score_p2, 8'h09);
            if (i == 10) chk("carry score_p2 at 10", score_p2, 8'h10);
        end

        // Straight win 11-0 for P1, then a held point, then restart.
        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 11; i++) begin
            step(0, 0, 0, 1, 0);
            if (i == 10) begin
                chk("win score at 10", score_p1, 8'h10);
                chk("win over at 10", {7'd0, game_over}, 8'd0);
            end
        end
        chk("win score_p1", score_p1, 8'h11);
        chk("win game_over", {7'd0, game_over}, 8'd1);
        chk("win playing", {7'd0, playing}, 8'd0);
        chk("win winner", {7'd0, winner}, 8'd0);
        step(0, 0, 0, 1, 0);
        chk("over hold score_p1", score_p1, 8'h11);
        chk("over hold game_over", {7'd0, game_over}, 8'd1);
        step(0, 1, 0, 0, 0);
        chk("restart score_p1", score_p1, 8'h00);
        chk("restart playing", {7'd0, playing}, 8'd1);
        chk("restart game_over", {7'd0, game_over}, 8'd0);

        // Deuce from 10-10: serve flips every point; P2 wins 13-11.
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 1);
        end
        chk("deuce 10 p1", score_p1, 8'h10);
        chk("deuce 10 p2", score_p2, 8'h10);
        sv = serve;
        step(0, 0, 0, 1, 0);
        chk("deuce 11-10 p1", score_p1, 8'h11);
        chk("deuce 11-10 serve", {7'd0, serve}, {7'd0, ~sv});
        step(0, 0, 0, 0, 1);
        chk("deuce 11-11 p2", score_p2, 8'h11);
        chk("deuce 11-11 serve", {7'd0, serve}, {7'd0, sv});
        step(0, 0, 0, 0, 1);
        chk("deuce 11-12 p2", score_p2, 8'h12);
        chk("deuce 11-12 serve", {7'd0, serve}, {7'd0, ~sv});
        chk("deuce 11-12 over", {7'd0, game_over}, 8'd0);
        step(0, 0, 0, 0, 1);
        chk("deuce 11-13 p2", score_p2, 8'h13);
        chk("deuce 11-13 over", {7'd0, game_over}, 8'd1);
        chk("deuce 11-13 winner", {7'd0, winner}, 8'd1);
        chk("deuce 11-13 serve held", {7'd0, serve}, {7'd0, ~sv});

        // Reset at 5-3 mid-game, then a point in IDLE is ignored.
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 1);
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("mid 5-3 p1", score_p1, 8'h05);
        chk("mid 5-3 p2", score_p2, 8'h03);
        step(1, 0, 0, 1, 0);
        chk("rst score_p1", score_p1, 8'h00);
        chk("rst score_p2", score_p2, 8'h00);
        chk("rst serve", {7'd0, serve}, 8'd0);
        chk("rst playing", {7'd0, playing}, 8'd0);
        chk("rst game_over", {7'd0, game_over}, 8'd0);
        step(0, 0, 0, 1, 0);
        chk("idle after rst score_p1", score_p1, 8'h00);

        // Random play against the model.
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 40);
            chk_model(n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
